// File: rtl/axil_regfile_pkg.sv
// Shared constants, FSM state types and address-decode helper for the AXI4-Lite control register file.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Word index of a byte address; the byte-lane bits are dropped.
  function automatic int unsigned idx_of(input logic [63:0] addr, input int unsigned data_width);
    logic [63:0] sh;
    sh = (data_width == 64) ? (addr >> 3) : (addr >> 2);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/axil_ctrl_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and the control register file slave.
interface axil_ctrl_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  // A beat transfers on a rising edge where valid and ready are both 1; a valid
  // source holds its payload stable until that edge.
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_ctrl_regfile_strb_reg.sv
// One DATA_WIDTH control register with per-byte write enables and synchronous reset.
module axil_strb_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [DATA_WIDTH-1:0]   d,
  output logic [DATA_WIDTH-1:0]   q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (strb[b]) q[b*8 +: 8] <= d[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_ctrl_regfile.sv
// AXI4-Lite slave: RW control registers, RO status registers, per-register write pulses.
// Define CTRL_IRQ_EN to add the IRQ_STATUS (W1C) / IRQ_ENABLE registers and the irq_o output.
module axil_ctrl_regfile
  import axil_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CTRL   = 8,
  parameter int NUM_STAT   = 4
) (
  input  logic                                           S_AXI_ACLK,
  input  logic                                           S_AXI_ARESET,
  axil_ctrl_regfile_if.slave                             bus,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]                 ctrl_o,
  output logic [NUM_CTRL-1:0]                            wr_pulse_o,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_WIDTH-1:0] stat_i,
`ifdef CTRL_IRQ_EN
  output logic                                           irq_o,
`endif
  output w_state_t                                       dbg_w_state,
  output r_state_t                                       dbg_r_state
);

  localparam int STRB_W = DATA_WIDTH/8;
`ifdef CTRL_IRQ_EN
  localparam int IRQ_REGS = 2;
`else
  localparam int IRQ_REGS = 0;
`endif
  localparam int unsigned MAPPED = NUM_CTRL + NUM_STAT + IRQ_REGS;

  logic clk, rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  logic unused_prot;
  assign unused_prot = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT};

  // ---------------- write channel ----------------
  w_state_t w_state, w_state_nxt;
  logic aw_done, w_done, aw_hs, w_hs, awready, wready, commit, bvalid_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, cur_addr;
  logic [DATA_WIDTH-1:0] w_data_q, cur_data;
  logic [STRB_W-1:0]     w_strb_q, cur_strb;
  logic [1:0]            bresp_q;
  logic [NUM_CTRL-1:0]   ctrl_we;
  int unsigned           w_idx;

  assign awready = (w_state == W_IDLE) && !aw_done && !rst;
  assign wready  = (w_state == W_IDLE) && !w_done && !rst;
  assign aw_hs   = bus.S_AXI_AWVALID && awready;
  assign w_hs    = bus.S_AXI_WVALID && wready;

  // A channel captured in an earlier cycle is replayed from its holding register.
  assign cur_addr = aw_done ? aw_addr_q : bus.S_AXI_AWADDR;
  assign cur_data = w_done ? w_data_q : bus.S_AXI_WDATA;
  assign cur_strb = w_done ? w_strb_q : bus.S_AXI_WSTRB;
  assign w_idx    = idx_of(64'(cur_addr), DATA_WIDTH);

  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    case (w_state)
      W_IDLE: if ((aw_done || aw_hs) && (w_done || w_hs)) begin
        commit      = 1'b1;
        w_state_nxt = W_RESP;
      end
      W_RESP: if (bus.S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      if (aw_hs) begin
        aw_done   <= 1'b1;
        aw_addr_q <= bus.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_done   <= 1'b1;
        w_data_q <= bus.S_AXI_WDATA;
        w_strb_q <= bus.S_AXI_WSTRB;
      end
      if (commit) begin
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (w_idx < MAPPED) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && bus.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      wr_pulse_o <= ctrl_we;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CTRL; k++) ctrl_we[k] = commit && (w_idx == unsigned'(k));
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    axil_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .we   (ctrl_we[g]),
      .strb (cur_strb),
      .d    (cur_data),
      .q    (ctrl_o[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef CTRL_IRQ_EN
  // ---------------- interrupt block ----------------
  localparam int unsigned IRQ_ST_IDX = NUM_CTRL + NUM_STAT;
  logic [DATA_WIDTH-1:0] stat0, stat0_q, irq_status, irq_enable, irq_clr;
  logic                  irq_q;

  assign stat0 = (NUM_STAT > 0) ? stat_i[DATA_WIDTH-1:0] : '0;

  always_comb begin
    for (int b = 0; b < STRB_W; b++)
      irq_clr[b*8 +: 8] = (commit && (w_idx == IRQ_ST_IDX) && cur_strb[b]) ? cur_data[b*8 +: 8] : 8'h00;
  end

  // Rising edges are OR'd in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat0_q    <= '0;
      irq_status <= '0;
      irq_q      <= 1'b0;
    end else begin
      stat0_q    <= stat0;
      irq_status <= (irq_status & ~irq_clr) | (stat0 & ~stat0_q);
      irq_q      <= |(irq_status & irq_enable);
    end
  end

  axil_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_irq_enable (
    .clk  (clk),
    .rst  (rst),
    .we   (commit && (w_idx == IRQ_ST_IDX + 1)),
    .strb (cur_strb),
    .d    (cur_data),
    .q    (irq_enable)
  );

  assign irq_o = irq_q;
`endif

  // ---------------- read channel ----------------
  r_state_t r_state, r_state_nxt;
  logic arready, ar_hs, rvalid_q;
  logic [DATA_WIDTH-1:0] rd_data, rdata_q;
  logic [1:0] rd_resp, rresp_q;
  int unsigned r_idx;

  assign arready = (r_state == R_IDLE) && !rst;
  assign ar_hs   = bus.S_AXI_ARVALID && arready;
  assign r_idx   = idx_of(64'(bus.S_AXI_ARADDR), DATA_WIDTH);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (r_idx == unsigned'(k)) begin
        rd_data = ctrl_o[k*DATA_WIDTH +: DATA_WIDTH];
        rd_resp = RESP_OKAY;
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (r_idx == unsigned'(NUM_CTRL + k)) begin
        rd_data = stat_i[k*DATA_WIDTH +: DATA_WIDTH];
        rd_resp = RESP_OKAY;
      end
    end
`ifdef CTRL_IRQ_EN
    if (r_idx == IRQ_ST_IDX) begin
      rd_data = irq_status;
      rd_resp = RESP_OKAY;
    end
    if (r_idx == IRQ_ST_IDX + 1) begin
      rd_data = irq_enable;
      rd_resp = RESP_OKAY;
    end
`endif
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (bus.S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && bus.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign bus.S_AXI_AWREADY = awready;
  assign bus.S_AXI_WREADY  = wready;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_BRESP   = bresp_q;
  assign bus.S_AXI_ARREADY = arready;
  assign bus.S_AXI_RVALID  = rvalid_q;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.S_AXI_RRESP   = rresp_q;
  assign dbg_w_state       = w_state;
  assign dbg_r_state       = r_state;

endmodule

// File: tb/tb_axil_ctrl_regfile.sv
// Directed plus randomized bench for axil_ctrl_regfile against a word-array model; CTRL_IRQ_EN adds IRQ steps.
module tb_axil_ctrl_regfile;
  import axil_regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NC = 8;
  localparam int NS = 4;
`ifdef CTRL_IRQ_EN
  localparam int IRQ_N = 2;
`else
  localparam int IRQ_N = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_ctrl_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [NC*DW-1:0] ctrl_o;
  logic [NC-1:0]    wr_pulse_o;
  logic [NS*DW-1:0] stat_i;
  w_state_t         dbg_w_state;
  r_state_t         dbg_r_state;
`ifdef CTRL_IRQ_EN
  logic             irq_o;
`endif

  axil_ctrl_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CTRL(NC), .NUM_STAT(NS)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus),
    .ctrl_o       (ctrl_o),
    .wr_pulse_o   (wr_pulse_o),
    .stat_i       (stat_i),
`ifdef CTRL_IRQ_EN
    .irq_o        (irq_o),
`endif
    .dbg_w_state  (dbg_w_state),
    .dbg_r_state  (dbg_r_state)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] ctrl_m [NC];
  logic [DW-1:0] stat_m [NS];
  int pulse_exp [NC];
  int pulse_cnt [NC];
  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) if (wr_pulse_o[k] === 1'b1) pulse_cnt[k]++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_stat(input int k, input logic [DW-1:0] v);
    stat_m[k] = v;
    stat_i[k*DW +: DW] = v;
  endtask

  function automatic logic [NC*DW-1:0] ctrl_model_vec();
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = ctrl_m[k];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bhold,
                           output logic [1:0] resp, output int b_lat);
    int cyc;
    bit aw_ok, w_ok, hs_aw, hs_w, early_b, stable;
    cyc = 0; aw_ok = 0; w_ok = 0; early_b = 0; stable = 1;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    bus.S_AXI_BREADY = (bhold == 0);
    while (!(aw_ok && w_ok) && cyc < 100) begin
      bus.S_AXI_AWVALID = !aw_ok && (cyc >= aw_dly);
      bus.S_AXI_WVALID  = !w_ok && (cyc >= w_dly);
      hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      if (bus.S_AXI_BVALID) early_b = 1;
      @(posedge clk); #1;
      aw_ok = aw_ok || hs_aw;
      w_ok  = w_ok || hs_w;
      cyc++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk("b_before_both_channels", early_b, 0);
    b_lat = 0;
    while (!bus.S_AXI_BVALID && b_lat < 100) begin
      @(posedge clk); #1;
      b_lat++;
    end
    resp = bus.S_AXI_BRESP;
    repeat (bhold) begin
      if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== resp || bus.S_AXI_AWREADY || bus.S_AXI_WREADY) stable = 0;
      @(posedge clk); #1;
    end
    if (bhold > 0) chk("b_stall_stable", stable, 1);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    chk("b_cleared", bus.S_AXI_BVALID, 0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int rhold,
                          output logic [DW-1:0] data, output logic [1:0] resp, output int r_lat);
    int cyc;
    bit ok, hs, stable;
    cyc = 0; ok = 0; stable = 1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = (rhold == 0);
    while (!ok && cyc < 100) begin
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(posedge clk); #1;
      ok = hs;
      cyc++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    r_lat = 0;
    while (!bus.S_AXI_RVALID && r_lat < 100) begin
      @(posedge clk); #1;
      r_lat++;
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    repeat (rhold) begin
      if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== data || bus.S_AXI_RRESP !== resp || bus.S_AXI_ARREADY) stable = 0;
      @(posedge clk); #1;
    end
    if (rhold > 0) chk("r_stall_stable", stable, 1);
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    chk("r_cleared", bus.S_AXI_RVALID, 0);
  endtask

  // Write through the bus, then apply the same write to the model and compare.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bhold);
    logic [1:0] resp, exp_resp;
    logic [DW-1:0] mask;
    int lat, idx;
    idx = int'(addr) / 4;
    axi_write(addr, data, strb, aw_dly, w_dly, bhold, resp, lat);
    if (idx < NC) begin
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      ctrl_m[idx] = (ctrl_m[idx] & ~mask) | (data & mask);
      pulse_exp[idx]++;
      exp_resp = RESP_OKAY;
    end else if (idx < NC + NS + IRQ_N) begin
      exp_resp = RESP_OKAY;
    end else begin
      exp_resp = RESP_SLVERR;
    end
    chk("bresp", resp, exp_resp);
    chk("b_latency", lat, 0);
    chk("ctrl_o_vs_model", ctrl_o, ctrl_model_vec());
  endtask

  // Expected value is taken when the read is issued, i.e. before any overlapping write.
  task automatic do_read(input logic [AW-1:0] addr, input int rhold);
    logic [DW-1:0] data, exp_data;
    logic [1:0] resp, exp_resp;
    int lat, idx;
    idx = int'(addr) / 4;
    exp_data = '0;
    exp_resp = RESP_SLVERR;
    if (idx < NC) begin
      exp_data = ctrl_m[idx];
      exp_resp = RESP_OKAY;
    end else if (idx < NC + NS) begin
      exp_data = stat_m[idx - NC];
      exp_resp = RESP_OKAY;
    end
    axi_read(addr, rhold, data, resp, lat);
    chk($sformatf("rdata@%02h", addr), data, exp_data);
    chk($sformatf("rresp@%02h", addr), resp, exp_resp);
    chk("r_latency", lat, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] rd;
    logic [1:0] rr;
    int lat, idx;
    logic [AW-1:0] addr;
    bit stable;

    rst = 1'b1;
    stat_i = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NC; k++) begin ctrl_m[k] = '0; pulse_exp[k] = 0; pulse_cnt[k] = 0; end
    for (int k = 0; k < NS; k++) stat_m[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.S_AXI_AWREADY, 0);
    chk("rst_wready", bus.S_AXI_WREADY, 0);
    chk("rst_arready", bus.S_AXI_ARREADY, 0);
    chk("rst_bvalid", bus.S_AXI_BVALID, 0);
    chk("rst_rvalid", bus.S_AXI_RVALID, 0);
    chk("rst_rdata", bus.S_AXI_RDATA, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_pulse", wr_pulse_o, 0);
    chk("rst_w_state", dbg_w_state, W_IDLE);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", bus.S_AXI_AWREADY, 1);
    chk("post_rst_wready", bus.S_AXI_WREADY, 1);
    chk("post_rst_arready", bus.S_AXI_ARREADY, 1);

    // Basic write then read-back of regs 0..3.
    for (int i = 0; i < 4; i++) do_write(AW'(i*4), DW'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(AW'(i*4), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("pulse_once_%0d", i), pulse_cnt[i], 1);

    // W leads AW by three cycles.
    do_write(8'h10, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    chk("reg4_deadbeef", ctrl_o[4*DW +: DW], 32'hDEADBEEF);

    // Byte strobes.
    do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(8'h00, 32'h12345678, 4'h5, 0, 1, 0);
    chk("strb_merge", ctrl_o[DW-1:0], 32'hFF34FF78);
    do_read(8'h00, 0);

    // Status and unmapped.
    set_stat(0, 32'hA5A5A5A5);
    do_read(AW'(NC*4), 0);
    do_write(AW'(NC*4), 32'h11111111, 4'hF, 0, 0, 0);
    do_read(AW'(NC*4), 0);
    do_read(8'h3C, 0);
    do_write(8'h3C, 32'h22222222, 4'hF, 0, 0, 0);
`ifndef CTRL_IRQ_EN
    do_read(8'h30, 0);
    do_read(8'h34, 0);
    do_write(8'h34, 32'h1, 4'hF, 0, 0, 0);
`endif

    // Backpressure on both response channels.
    do_write(8'h08, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    do_read(8'h08, 5);

    // Read and write to the same register in the same cycle.
    fork
      do_write(8'h14, 32'h5A5A0001, 4'hF, 0, 0, 0);
      do_read(8'h14, 0);
    join
    do_read(8'h14, 0);

    // Random traffic; IRQ indices are left to the directed steps.
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 13);
      if (idx >= 12) idx = idx + 2;
      addr = AW'(idx*4 + int'($urandom_range(0, 3)));
      case ($urandom_range(0, 3))
        0, 1: do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
        2: do_read(addr, $urandom_range(0, 2));
        default: set_stat($urandom_range(0, NS-1), $urandom);
      endcase
    end

`ifdef CTRL_IRQ_EN
    set_stat(0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    do_write(8'h30, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(8'h34, 32'h1, 4'hF, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_idle", irq_o, 0);
    set_stat(0, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_raised", irq_o, 1);
    axi_read(8'h30, 0, rd, rr, lat);
    chk("irq_status_set", rd, 32'h1);
    axi_read(8'h34, 0, rd, rr, lat);
    chk("irq_enable_rd", rd, 32'h1);
    do_write(8'h30, 32'h1, 4'hF, 0, 0, 0);
    chk("irq_cleared", irq_o, 0);
    axi_read(8'h30, 0, rd, rr, lat);
    chk("irq_status_clr", rd, 32'h0);
`endif

    // Reset in the middle of a write: AW captured, W pending.
    bus.S_AXI_AWADDR = 8'h04;
    bus.S_AXI_AWVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'h77777777;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    rst = 1'b1;
    stable = 1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.S_AXI_BVALID || wr_pulse_o != 0) stable = 0;
    end
    bus.S_AXI_WVALID = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.S_AXI_BVALID || wr_pulse_o != 0) stable = 0;
    end
    bus.S_AXI_BREADY = 1'b0;
    chk("no_b_after_reset", stable, 1);
    chk("awready_after_reset", bus.S_AXI_AWREADY, 1);
    for (int k = 0; k < NC; k++) ctrl_m[k] = '0;
    for (int k = 0; k < NC; k++) do_read(AW'(k*4), 0);

    for (int k = 0; k < NC; k++) chk($sformatf("pulse_count_%0d", k), pulse_cnt[k], pulse_exp[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
